// File: rtl/mmr_intr_coalescer.sv
// mmr_intr_coalescer
//   Interrupt coalescer sitting behind an MMR status/mask block. The enabled
//   status bits are OR-reduced to one pending level. Rising bits (new events)
//   are counted, and irq is raised when the count reaches a threshold or a
//   timeout expires. After irq drops, a holdoff window keeps it low for a
//   minimum number of cycles.
//
// Ports
//   clock        system clock, all logic on posedge
//   reset_n      synchronous active-low reset
//   isr          N_WORDS x 32 interrupt status words
//   imr          N_WORDS x 32 interrupt mask words (1 = enabled)
//   cfg_enable   coalescing enable; 0 = pass-through
//   cfg_thresh   event count that fires irq
//   cfg_timeout  coalescing timeout in cycles; 0 = no timeout
//   cfg_holdoff  minimum irq-low cycles after deassert
//   irq          registered level interrupt
//   irq_count    count of irq rising edges, wraps at 2^32
//   state_dbg    current FSM state encoding
module mmr_intr_coalescer #(
    parameter int unsigned N_WORDS   = 2,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned TMR_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N_WORDS-1:0][31:0]   isr,
    input  logic [N_WORDS-1:0][31:0]   imr,
    input  logic                       cfg_enable,
    input  logic [CNT_WIDTH-1:0]       cfg_thresh,
    input  logic [TMR_WIDTH-1:0]       cfg_timeout,
    input  logic [TMR_WIDTH-1:0]       cfg_holdoff,
    output logic                       irq,
    output logic [31:0]                irq_count,
    output logic [1:0]                 state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COALESCE = 2'd1,
        ASSERT   = 2'd2,
        HOLDOFF  = 2'd3
    } state_t;

    state_t                     state, state_next;
    logic [CNT_WIDTH-1:0]       count, count_next, count_inc;
    logic [TMR_WIDTH-1:0]       timer, timer_next, timer_inc;
    logic [N_WORDS-1:0][31:0]   masked, masked_q;
    logic                       pending, new_event, irq_next;

    // Several newly set bits in one cycle still count as a single event.
    always_comb begin
        masked    = isr & imr;
        pending   = |masked;
        new_event = |(masked & ~masked_q);
        count_inc = (count == '1) ? count : count + CNT_WIDTH'(1);
        timer_inc = (timer == '1) ? timer : timer + TMR_WIDTH'(1);
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            timer     <= '0;
            masked_q  <= '0;
            irq       <= 1'b0;
            irq_count <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            timer    <= timer_next;
            masked_q <= masked;
            irq      <= irq_next;
            if (irq_next && !irq)
                irq_count <= irq_count + 32'd1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        count_next = count;
        timer_next = timer;
        unique case (state)
            IDLE: begin
                count_next = '0;
                timer_next = '0;
                if (pending && (!cfg_enable || cfg_thresh <= CNT_WIDTH'(1))) begin
                    state_next = ASSERT;
                end else if (new_event) begin
                    state_next = COALESCE;
                    count_next = CNT_WIDTH'(1);
                end
            end
            COALESCE: begin
                timer_next = timer_inc;
                count_next = new_event ? count_inc : count;
                // A software clear wins over any firing condition.
                if (!pending) begin
                    state_next = IDLE;
                    count_next = '0;
                    timer_next = '0;
                end else if (!cfg_enable
                             || (count_next >= cfg_thresh)
                             || ((cfg_timeout != '0) && (timer_inc >= cfg_timeout))) begin
                    state_next = ASSERT;
                end
            end
            ASSERT: begin
                if (!pending) begin
                    timer_next = '0;
                    count_next = '0;
                    state_next = (cfg_holdoff == '0) ? IDLE : HOLDOFF;
                end
            end
            HOLDOFF: begin
                // Events arriving here are not counted; pending re-evaluates in IDLE.
                if (timer_inc >= cfg_holdoff) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        irq_next  = (state_next == ASSERT);
        state_dbg = state;
    end

endmodule

// File: tb/tb_mmr_intr_coalescer.sv
module tb_mmr_intr_coalescer;

    logic                 clock;
    logic                 reset_n;
    logic [1:0][31:0]     isr;
    logic [1:0][31:0]     imr;
    logic                 cfg_enable;
    logic [7:0]           cfg_thresh;
    logic [15:0]          cfg_timeout;
    logic [15:0]          cfg_holdoff;
    logic                 irq;
    logic [31:0]          irq_count;
    logic [1:0]           state_dbg;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    mmr_intr_coalescer #(
        .N_WORDS   (2),
        .CNT_WIDTH (8),
        .TMR_WIDTH (16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .isr         (isr),
        .imr         (imr),
        .cfg_enable  (cfg_enable),
        .cfg_thresh  (cfg_thresh),
        .cfg_timeout (cfg_timeout),
        .cfg_holdoff (cfg_holdoff),
        .irq         (irq),
        .irq_count   (irq_count),
        .state_dbg   (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and settle outputs before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_irq, input logic [31:0] exp_cnt,
                             input logic [1:0] exp_state);
        check({tag, ".irq"},   {31'd0, irq}, {31'd0, exp_irq});
        check({tag, ".count"}, irq_count, exp_cnt);
        check({tag, ".state"}, {30'd0, state_dbg}, {30'd0, exp_state});
    endtask

    initial begin
        reset_n     = 1'b0;
        isr         = '0;
        imr         = '0;
        cfg_enable  = 1'b0;
        cfg_thresh  = 8'd4;
        cfg_timeout = 16'd0;
        cfg_holdoff = 16'd0;
        tick();
        tick();
        check_all("reset", 1'b0, 32'd0, 2'd0);
        reset_n = 1'b1;

        // Pass-through
        imr[0] = 32'h1;
        isr[0] = 32'h1;
        tick();
        check_all("pass_on", 1'b1, 32'd1, 2'd2);
        isr[0] = 32'h0;
        tick();
        check_all("pass_off", 1'b0, 32'd1, 2'd0);
        tick();

        // Threshold of 4 distinct new bits
        cfg_enable = 1'b1;
        cfg_thresh = 8'd4;
        imr[0]     = 32'hF;
        isr[0]     = 32'h1;
        tick();
        check_all("thr_ev1", 1'b0, 32'd1, 2'd1);
        isr[0] = 32'h3;
        tick();
        check_all("thr_ev2", 1'b0, 32'd1, 2'd1);
        isr[0] = 32'h7;
        tick();
        check_all("thr_ev3", 1'b0, 32'd1, 2'd1);
        isr[0] = 32'hF;
        tick();
        check_all("thr_ev4", 1'b1, 32'd2, 2'd2);
        isr[0] = 32'h0;
        tick();
        check_all("thr_clr", 1'b0, 32'd2, 2'd0);

        // Timeout: single event, thresh 8, timeout 10
        cfg_thresh  = 8'd8;
        cfg_timeout = 16'd10;
        isr[0]      = 32'h1;
        tick();
        check_all("tmo_start", 1'b0, 32'd2, 2'd1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("tmo_wait.irq", {31'd0, irq}, 32'd0);
        end
        tick();
        check_all("tmo_fire", 1'b1, 32'd3, 2'd2);
        isr[0] = 32'h0;
        tick();
        check_all("tmo_clr", 1'b0, 32'd3, 2'd0);

        // Masked event stays idle
        cfg_timeout = 16'd0;
        imr         = '0;
        isr[0]      = 32'h1;
        tick();
        tick();
        check_all("masked", 1'b0, 32'd3, 2'd0);
        isr[0] = 32'h0;

        // Event in word 1 cleared during coalescing
        imr[1] = 32'h100;
        isr[1] = 32'h100;
        tick();
        check_all("w1_coal", 1'b0, 32'd3, 2'd1);
        isr[1] = 32'h0;
        tick();
        check_all("w1_clr", 1'b0, 32'd3, 2'd0);
        tick();
        check_all("w1_quiet", 1'b0, 32'd3, 2'd0);

        // Holdoff of 5 with an event arriving during holdoff
        imr[1]      = 32'h0;
        imr[0]      = 32'h1;
        cfg_thresh  = 8'd1;
        cfg_holdoff = 16'd5;
        isr[0]      = 32'h1;
        tick();
        check_all("ho_assert", 1'b1, 32'd4, 2'd2);
        isr[0] = 32'h0;
        tick();
        check_all("ho_enter", 1'b0, 32'd4, 2'd3);
        isr[0] = 32'h1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_all("ho_wait", 1'b0, 32'd4, 2'd3);
        end
        tick();
        check_all("ho_exit", 1'b0, 32'd4, 2'd0);
        tick();
        check_all("ho_reassert", 1'b1, 32'd5, 2'd2);

        // Reset while asserted
        reset_n = 1'b0;
        tick();
        check_all("rst_assert", 1'b0, 32'd0, 2'd0);
        reset_n = 1'b1;

        // Bit still pending after reset counts as a new event
        cfg_thresh = 8'd4;
        tick();
        check_all("post_rst_ev", 1'b0, 32'd0, 2'd1);
        tick();
        check_all("post_rst_hold", 1'b0, 32'd0, 2'd1);

        // Enable dropped mid-coalesce forces assert
        cfg_enable = 1'b0;
        tick();
        check_all("en_drop", 1'b1, 32'd1, 2'd2);
        isr[0] = 32'h0;
        cfg_holdoff = 16'd0;
        tick();
        check_all("en_drop_clr", 1'b0, 32'd1, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
